// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and helpers for the stream width converter
package stream_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    UPSIZE   = 2'd1,
    DOWNSIZE = 2'd2
  } conv_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } dsz_state_e;

  // Wide-to-narrow ratio; a zero width yields 1 so elaboration can still report it
  function automatic int ratio_f(input int in_w, input int out_w);
    int hi;
    int lo;
    hi = (in_w > out_w) ? in_w : out_w;
    lo = (in_w > out_w) ? out_w : in_w;
    if (lo <= 0) begin
      return 1;
    end
    return hi / lo;
  endfunction

  function automatic conv_mode_e mode_f(input int in_w, input int out_w);
    if (out_w > in_w) begin
      return UPSIZE;
    end
    if (in_w > out_w) begin
      return DOWNSIZE;
    end
    return PASS;
  endfunction

endpackage

// File: rtl/stream_if.sv
// rtl/stream_if.sv - valid/ready stream bundle for system-level hookup
interface stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport src (output data, output valid, output last, input ready);
  modport snk (input data, input valid, input last, output ready);
endinterface

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - full-throughput single-entry valid/ready register stage
module stream_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // The entry is free when empty or when the sink drains it this same cycle
  assign s_ready = !valid_q || m_ready;
  assign m_data  = data_q;
  assign m_valid = valid_q;

  // Load on accept, otherwise drop the entry once the sink takes it
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (s_valid && s_ready) begin
      data_d  = s_data;
      valid_d = 1'b1;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/stream_width_conv.sv
// rtl/stream_width_conv.sv - valid/ready width converter (pack, slice or pass); framing via STREAM_WIDTH_CONV_LAST_EN
module stream_width_conv
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
`ifdef STREAM_WIDTH_CONV_LAST_EN
  ,
  localparam int KEEP_W = (OUT_WIDTH > IN_WIDTH) ? ratio_f(IN_WIDTH, OUT_WIDTH) : 1
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready
`ifdef STREAM_WIDTH_CONV_LAST_EN
  ,
  input  logic                 s_last,
  output logic                 m_last,
  output logic [KEEP_W-1:0]    m_keep
`endif
);

  localparam int RATIO = ratio_f(IN_WIDTH, OUT_WIDTH);
  localparam int MAXW  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int MINW  = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam conv_mode_e MODE = mode_f(IN_WIDTH, OUT_WIDTH);

`ifdef STREAM_WIDTH_CONV_LAST_EN
  // Slice payload carries last and keep above the data word
  localparam int SL_W = OUT_WIDTH + 1 + KEEP_W;
`else
  localparam int SL_W = OUT_WIDTH;
`endif

  if (MINW <= 0) begin : g_bad_zero
    $error("stream_width_conv: widths must be non-zero");
  end
  if (MINW > 0 && RATIO * MINW != MAXW) begin : g_bad_ratio
    $error("stream_width_conv: wider width must be a multiple of the narrower");
  end

  if (MODE == PASS) begin : g_pass
    logic [SL_W-1:0] sl_in, sl_out;

`ifdef STREAM_WIDTH_CONV_LAST_EN
    assign sl_in = {s_last, 1'b1, s_data};
    assign {m_last, m_keep, m_data} = sl_out;
`else
    assign sl_in  = s_data;
    assign m_data = sl_out;
`endif

    stream_reg_slice #(.WIDTH(SL_W)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .s_data  (sl_in),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .m_data  (sl_out),
      .m_valid (m_valid),
      .m_ready (m_ready)
    );

  end else if (MODE == UPSIZE) begin : g_up
    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] pack_q, pack_d;
    logic [OUT_WIDTH-1:0] word;
    logic                 flush;
    logic                 sl_ready;
    logic [SL_W-1:0]      sl_in, sl_out;

    // A beat completes the word on the top lane, or early on a packet end
`ifdef STREAM_WIDTH_CONV_LAST_EN
    assign flush = (cnt_q == CNT_W'(RATIO - 1)) || s_last;
`else
    assign flush = (cnt_q == CNT_W'(RATIO - 1));
`endif

    // Only a completing beat needs room in the output stage
    assign s_ready = !flush || sl_ready;

    // Merge the incoming beat into its lane; lanes above it are still zero
    always_comb begin
      word = pack_q;
      word[cnt_q*IN_WIDTH +: IN_WIDTH] = s_data;
    end

    // Lane counter and partial word; cleared after every emitted word
    always_comb begin
      cnt_d  = cnt_q;
      pack_d = pack_q;
      if (s_valid && s_ready) begin
        if (flush) begin
          cnt_d  = '0;
          pack_d = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          pack_d = word;
        end
      end
    end

    // Packing registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        pack_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        pack_q <= pack_d;
      end
    end

`ifdef STREAM_WIDTH_CONV_LAST_EN
    logic [KEEP_W-1:0] keep;

    // Lanes 0..cnt hold real data in the word being emitted
    always_comb begin
      keep = '0;
      for (int i = 0; i < KEEP_W; i++) begin
        keep[i] = (i <= int'(cnt_q));
      end
    end

    assign sl_in = {s_last, keep, word};
    assign {m_last, m_keep, m_data} = sl_out;
`else
    assign sl_in  = word;
    assign m_data = sl_out;
`endif

    stream_reg_slice #(.WIDTH(SL_W)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .s_data  (sl_in),
      .s_valid (s_valid && flush),
      .s_ready (sl_ready),
      .m_data  (sl_out),
      .m_valid (m_valid),
      .m_ready (m_ready)
    );

  end else begin : g_down
    localparam int IDX_W = $clog2(RATIO);

    dsz_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic                last_slice;

    assign last_slice = (idx_q == IDX_W'(RATIO - 1));
    // Reload is allowed while the final slice is being taken, avoiding a bubble
    assign s_ready    = (state_q == EMPTY) || (last_slice && m_ready);
    assign m_valid    = (state_q == DRAIN);
    assign m_data     = hold_q[idx_q*OUT_WIDTH +: OUT_WIDTH];

`ifdef STREAM_WIDTH_CONV_LAST_EN
    logic last_q, last_d;
    assign m_last = m_valid && last_slice && last_q;
    assign m_keep = 1'b1;
`endif

    // Load a new word on accept, otherwise step through slices as they drain
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
`ifdef STREAM_WIDTH_CONV_LAST_EN
      last_d  = last_q;
`endif
      if (s_valid && s_ready) begin
        state_d = DRAIN;
        idx_d   = '0;
        hold_d  = s_data;
`ifdef STREAM_WIDTH_CONV_LAST_EN
        last_d  = s_last;
`endif
      end else if (m_valid && m_ready) begin
        if (last_slice) begin
          state_d = EMPTY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // EMPTY/DRAIN state machine with its hold register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        idx_q   <= '0;
        hold_q  <= '0;
`ifdef STREAM_WIDTH_CONV_LAST_EN
        last_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        hold_q  <= hold_d;
`ifdef STREAM_WIDTH_CONV_LAST_EN
        last_q  <= last_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_width_conv.sv
// tb/tb_stream_width_conv.sv - directed table-driven bench for stream_width_conv
module tb_stream_width_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // unit 0: 16->32, unit 1: 32->16, unit 2: 8->32, unit 3: 16->16
  logic [15:0] a_sd; logic a_sv, a_sr, a_mv, a_mr; logic [31:0] a_md;
  logic [31:0] b_sd; logic b_sv, b_sr, b_mv, b_mr; logic [15:0] b_md;
  logic [7:0]  c_sd; logic c_sv, c_sr, c_mv, c_mr; logic [31:0] c_md;
  logic [15:0] d_sd; logic d_sv, d_sr, d_mv, d_mr; logic [15:0] d_md;
`ifdef STREAM_WIDTH_CONV_LAST_EN
  logic a_sl, a_ml; logic [1:0] a_mk;
  logic b_sl, b_ml; logic [0:0] b_mk;
  logic c_sl, c_ml; logic [3:0] c_mk;
  logic d_sl, d_ml; logic [0:0] d_mk;
`endif

  stream_width_conv #(.IN_WIDTH(16), .OUT_WIDTH(32)) u_up16 (
    .clk(clk), .rst(rst), .s_data(a_sd), .s_valid(a_sv), .s_ready(a_sr),
    .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr)
`ifdef STREAM_WIDTH_CONV_LAST_EN
    , .s_last(a_sl), .m_last(a_ml), .m_keep(a_mk)
`endif
  );

  stream_width_conv #(.IN_WIDTH(32), .OUT_WIDTH(16)) u_dn (
    .clk(clk), .rst(rst), .s_data(b_sd), .s_valid(b_sv), .s_ready(b_sr),
    .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr)
`ifdef STREAM_WIDTH_CONV_LAST_EN
    , .s_last(b_sl), .m_last(b_ml), .m_keep(b_mk)
`endif
  );

  stream_width_conv #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_up8 (
    .clk(clk), .rst(rst), .s_data(c_sd), .s_valid(c_sv), .s_ready(c_sr),
    .m_data(c_md), .m_valid(c_mv), .m_ready(c_mr)
`ifdef STREAM_WIDTH_CONV_LAST_EN
    , .s_last(c_sl), .m_last(c_ml), .m_keep(c_mk)
`endif
  );

  stream_width_conv #(.IN_WIDTH(16), .OUT_WIDTH(16)) u_pass (
    .clk(clk), .rst(rst), .s_data(d_sd), .s_valid(d_sv), .s_ready(d_sr),
    .m_data(d_md), .m_valid(d_mv), .m_ready(d_mr)
`ifdef STREAM_WIDTH_CONV_LAST_EN
    , .s_last(d_sl), .m_last(d_ml), .m_keep(d_mk)
`endif
  );

  typedef struct {
    int          unit;
    logic [31:0] sd;
    logic        sv;
    logic        mr;
    logic        esr;
    logic        emv;
    logic [31:0] emd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input int u, input logic [31:0] sd, input logic sv,
                              input logic mr, input logic esr, input logic emv,
                              input logic [31:0] emd);
    vec_t v;
    v.unit = u; v.sd = sd; v.sv = sv; v.mr = mr;
    v.esr = esr; v.emv = emv; v.emd = emd;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_all();
    a_sd = '0; a_sv = 1'b0; a_mr = 1'b1;
    b_sd = '0; b_sv = 1'b0; b_mr = 1'b1;
    c_sd = '0; c_sv = 1'b0; c_mr = 1'b1;
    d_sd = '0; d_sv = 1'b0; d_mr = 1'b1;
`ifdef STREAM_WIDTH_CONV_LAST_EN
    a_sl = 1'b0; b_sl = 1'b0; c_sl = 1'b0; d_sl = 1'b0;
`endif
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 1 ns later
  task automatic run_vec(input int i, input vec_t v);
    logic        sr, mv;
    logic [31:0] md;
    idle_all();
    case (v.unit)
      0: begin a_sd = v.sd[15:0]; a_sv = v.sv; a_mr = v.mr; end
      1: begin b_sd = v.sd;       b_sv = v.sv; b_mr = v.mr; end
      2: begin c_sd = v.sd[7:0];  c_sv = v.sv; c_mr = v.mr; end
      default: begin d_sd = v.sd[15:0]; d_sv = v.sv; d_mr = v.mr; end
    endcase
    #1;
    case (v.unit)
      0: begin sr = a_sr; mv = a_mv; md = a_md; end
      1: begin sr = b_sr; mv = b_mv; md = {16'h0, b_md}; end
      2: begin sr = c_sr; mv = c_mv; md = c_md; end
      default: begin sr = d_sr; mv = d_mv; md = {16'h0, d_md}; end
    endcase
    check($sformatf("row%0d_u%0d_s_ready", i, v.unit), {31'h0, sr}, {31'h0, v.esr});
    check($sformatf("row%0d_u%0d_m_valid", i, v.unit), {31'h0, mv}, {31'h0, v.emv});
    if (v.emv) check($sformatf("row%0d_u%0d_m_data", i, v.unit), md, v.emd);
    @(negedge clk);
  endtask

  initial begin
    // 16->32: pack, latency, backpressure with same-cycle drain and refill
    add(0, 'h1111, 1, 1, 1, 0, 0);
    add(0, 'h2222, 1, 1, 1, 0, 0);
    add(0, 0,      0, 0, 1, 1, 'h22221111);
    add(0, 'h3333, 1, 0, 1, 1, 'h22221111);
    add(0, 'h4444, 1, 0, 0, 1, 'h22221111);
    add(0, 'h4444, 1, 1, 1, 1, 'h22221111);
    add(0, 0,      0, 1, 1, 1, 'h44443333);
    add(0, 0,      0, 1, 1, 0, 0);
    // 32->16: lowest slice first, back-to-back words, stall on last slice
    add(1, 'hAAAA5555, 1, 1, 1, 0, 0);
    add(1, 0,          0, 1, 0, 1, 'h5555);
    add(1, 0,          0, 1, 1, 1, 'hAAAA);
    add(1, 'h12345678, 1, 1, 1, 0, 0);
    add(1, 'h9ABCDEF0, 1, 1, 0, 1, 'h5678);
    add(1, 'h9ABCDEF0, 1, 1, 1, 1, 'h1234);
    add(1, 0,          0, 1, 0, 1, 'hDEF0);
    add(1, 0,          0, 0, 0, 1, 'h9ABC);
    add(1, 0,          0, 1, 1, 1, 'h9ABC);
    add(1, 0,          0, 1, 1, 0, 0);
    // 8->32: eight back-to-back beats
    add(2, 'h01, 1, 1, 1, 0, 0);
    add(2, 'h02, 1, 1, 1, 0, 0);
    add(2, 'h03, 1, 1, 1, 0, 0);
    add(2, 'h04, 1, 1, 1, 0, 0);
    add(2, 'h05, 1, 1, 1, 1, 'h04030201);
    add(2, 'h06, 1, 1, 1, 0, 0);
    add(2, 'h07, 1, 1, 1, 0, 0);
    add(2, 'h08, 1, 1, 1, 0, 0);
    add(2, 0,    0, 1, 1, 1, 'h08070605);
    add(2, 0,    0, 1, 1, 0, 0);
    // 16->16: register slice with a stalled beat
    add(3, 'hABCD, 1, 1, 1, 0, 0);
    add(3, 'h1234, 1, 0, 0, 1, 'hABCD);
    add(3, 'h1234, 1, 1, 1, 1, 'hABCD);
    add(3, 0,      0, 1, 1, 1, 'h1234);
    add(3, 0,      0, 1, 1, 0, 0);

    idle_all();
    rst = 1'b1;
    #7;
    check("rst_up16_s_ready", {31'h0, a_sr}, 32'h1);
    check("rst_up16_m_valid", {31'h0, a_mv}, 32'h0);
    check("rst_up16_m_data",  a_md, 32'h0);
    check("rst_dn_s_ready",   {31'h0, b_sr}, 32'h1);
    check("rst_dn_m_valid",   {31'h0, b_mv}, 32'h0);
    check("rst_dn_m_data",    {16'h0, b_md}, 32'h0);
    check("rst_up8_s_ready",  {31'h0, c_sr}, 32'h1);
    check("rst_up8_m_valid",  {31'h0, c_mv}, 32'h0);
    check("rst_up8_m_data",   c_md, 32'h0);
    check("rst_pass_s_ready", {31'h0, d_sr}, 32'h1);
    check("rst_pass_m_valid", {31'h0, d_mv}, 32'h0);
    check("rst_pass_m_data",  {16'h0, d_md}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset after one of two upsize beats discards the partial word
    idle_all();
    a_sd = 16'hDEAD; a_sv = 1'b1;
    @(negedge clk);
    a_sv = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_m_valid_in_reset", {31'h0, a_mv}, 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    a_sd = 16'hBEEF; a_sv = 1'b1;
    #1;
    check("midrst_beef_m_valid", {31'h0, a_mv}, 32'h0);
    @(negedge clk);
    a_sd = 16'hCAFE;
    #1;
    check("midrst_cafe_m_valid", {31'h0, a_mv}, 32'h0);
    check("midrst_cafe_s_ready", {31'h0, a_sr}, 32'h1);
    @(negedge clk);
    a_sv = 1'b0;
    #1;
    check("midrst_word_m_valid", {31'h0, a_mv}, 32'h1);
    check("midrst_word_m_data",  a_md, 32'hCAFEBEEF);
    @(negedge clk);
    #1;
    check("midrst_after_m_valid", {31'h0, a_mv}, 32'h0);
    @(negedge clk);

`ifdef STREAM_WIDTH_CONV_LAST_EN
    // Short packet on 8->32 flushes early with zero padding
    idle_all();
    c_sv = 1'b1; c_sd = 8'h01;
    @(negedge clk); c_sd = 8'h02;
    @(negedge clk); c_sd = 8'h03; c_sl = 1'b1;
    @(negedge clk); c_sv = 1'b0; c_sl = 1'b0;
    #1;
    check("last_up8_m_valid", {31'h0, c_mv}, 32'h1);
    check("last_up8_m_data",  c_md, 32'h00030201);
    check("last_up8_m_keep",  {28'h0, c_mk}, 32'h7);
    check("last_up8_m_last",  {31'h0, c_ml}, 32'h1);
    @(negedge clk);
    c_sv = 1'b1; c_sd = 8'h11;
    @(negedge clk); c_sd = 8'h22;
    @(negedge clk); c_sd = 8'h33;
    @(negedge clk); c_sd = 8'h44;
    @(negedge clk); c_sv = 1'b0;
    #1;
    check("full_up8_m_data", c_md, 32'h44332211);
    check("full_up8_m_keep", {28'h0, c_mk}, 32'hF);
    check("full_up8_m_last", {31'h0, c_ml}, 32'h0);
    @(negedge clk);
    // Downsize marks only the final slice of a last word
    b_sd = 32'hAAAA5555; b_sv = 1'b1; b_sl = 1'b1;
    @(negedge clk); b_sv = 1'b0; b_sl = 1'b0;
    #1;
    check("last_dn_slice0_m_last", {31'h0, b_ml}, 32'h0);
    check("last_dn_slice0_m_keep", {31'h0, b_mk}, 32'h1);
    @(negedge clk);
    #1;
    check("last_dn_slice1_m_last", {31'h0, b_ml}, 32'h1);
    check("last_dn_slice1_m_data", {16'h0, b_md}, 32'hAAAA);
    @(negedge clk);
    // Pass mode forwards last
    d_sd = 16'h7777; d_sv = 1'b1; d_sl = 1'b1;
    @(negedge clk); d_sv = 1'b0; d_sl = 1'b0;
    #1;
    check("last_pass_m_last",  {31'h0, d_ml}, 32'h1);
    check("last_pass_m_valid", {31'h0, d_mv}, 32'h1);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
